// File: rtl/msi_irq_scheduler.sv
// Round-robin MSI interrupt scheduler for PF0: per-source pending, one outstanding MSI, retry/backoff/timeout.
// Define MSI_IRQ_STATS_EN to add saturating stat_sent/stat_fail/stat_drop counters.
module msi_irq_scheduler #(
    parameter int unsigned NUM_SRC        = 8,
    parameter int unsigned RETRY_MAX      = 3,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_req,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [NUM_SRC-1:0] irq_drop,
    input  logic [3:0]         cfg_interrupt_msi_enable,
    input  logic [11:0]        cfg_interrupt_msi_mmenable,
    output logic [31:0]        cfg_interrupt_msi_int,
    input  logic               cfg_interrupt_msi_sent,
    input  logic               cfg_interrupt_msi_fail,
    output logic [7:0]         cfg_interrupt_msi_function_number,
    output logic [2:0]         cfg_interrupt_msi_attr,
    output logic               busy
`ifdef MSI_IRQ_STATS_EN
    ,
    output logic [31:0]        stat_sent,
    output logic [31:0]        stat_fail,
    output logic [31:0]        stat_drop
`endif
);

    localparam int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned BK_W    = 8;
    localparam int unsigned TMR_W   = 16;
    localparam int unsigned VEC_W   = 5;

    localparam logic [SRC_W-1:0]   LAST_SRC  = SRC_W'(NUM_SRC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
    localparam logic [BK_W-1:0]    BK_LAST   = BK_W'(BACKOFF_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BACKOFF
    } state_t;

    state_t             state_q, state_n;
    logic [SRC_W-1:0]   cur_src_q, cur_src_n;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_n;
    logic [RETRY_W-1:0] retry_q, retry_n, retry_inc;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic [BK_W-1:0]    bk_q, bk_n;
    logic [NUM_SRC-1:0] pending_q, pending_n;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] ack_n, drop_n;
    logic [NUM_SRC-1:0] cur_onehot;
    logic [31:0]        int_n;
    logic               busy_n;
    logic               sel_valid;
    logic [SRC_W-1:0]   sel_src;
    logic               msi_en;
    logic               unused_cfg;

    assign msi_en     = cfg_interrupt_msi_enable[0];
    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};
    assign cur_onehot = NUM_SRC'(1) << cur_src_q;
    assign retry_inc  = retry_q + RETRY_W'(1);

    assign cfg_interrupt_msi_function_number = 8'd0;
    assign cfg_interrupt_msi_attr            = 3'd0;

    // Vector aliasing: the hard block grants 2^mm vectors, 6/7 behave as 5.
    function automatic logic [31:0] vec_onehot(input logic [SRC_W-1:0] src, input logic [2:0] mm);
        logic [2:0]       lg;
        logic [VEC_W-1:0] mask;
        lg   = (mm > 3'd5) ? 3'd5 : mm;
        mask = VEC_W'((32'd1 << lg) - 32'd1);
        return 32'd1 << (VEC_W'(src) & mask);
    endfunction

    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] src);
        return (src == LAST_SRC) ? '0 : src + SRC_W'(1);
    endfunction

    // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_src   = '0;
        idx       = 0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_SRC)) begin
                idx = idx - int'(NUM_SRC);
            end
            if (pending_q[SRC_W'(idx)]) begin
                sel_valid = 1'b1;
                sel_src   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        cur_src_n = cur_src_q;
        rr_ptr_n  = rr_ptr_q;
        retry_n   = retry_q;
        timer_n   = timer_q;
        bk_n      = bk_q;
        clr_mask  = '0;
        ack_n     = '0;
        drop_n    = '0;
        int_n     = '0;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    if (!msi_en) begin
                        drop_n   = pending_q;
                        clr_mask = pending_q;
                    end else if (sel_valid) begin
                        cur_src_n = sel_src;
                        retry_n   = '0;
                        state_n   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                timer_n = timer_q + TMR_W'(1);
                if (cfg_interrupt_msi_sent) begin
                    ack_n    = cur_onehot;
                    clr_mask = cur_onehot;
                    rr_ptr_n = next_ptr(cur_src_q);
                    state_n  = S_IDLE;
                end else if (cfg_interrupt_msi_fail || (timer_q == TMR_LAST)) begin
                    retry_n = retry_inc;
                    if (retry_inc == RETRY_LIM) begin
                        drop_n   = cur_onehot;
                        clr_mask = cur_onehot;
                        rr_ptr_n = next_ptr(cur_src_q);
                        state_n  = S_IDLE;
                    end else begin
                        bk_n    = '0;
                        state_n = S_BACKOFF;
                    end
                end
            end
            S_BACKOFF: begin
                if (!msi_en) begin
                    drop_n   = cur_onehot;
                    clr_mask = cur_onehot;
                    rr_ptr_n = next_ptr(cur_src_q);
                    state_n  = S_IDLE;
                end else if (bk_q == BK_LAST) begin
                    state_n = S_ISSUE;
                end else begin
                    bk_n = bk_q + BK_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A request in the same cycle as its ack/drop re-arms the source.
        pending_n = (pending_q & ~clr_mask) | irq_req;
        if (state_n == S_ISSUE) begin
            int_n = vec_onehot(cur_src_n, cfg_interrupt_msi_mmenable[2:0]);
        end
        busy_n = (state_n != S_IDLE) || (|pending_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= S_IDLE;
            cur_src_q             <= '0;
            rr_ptr_q              <= '0;
            retry_q               <= '0;
            timer_q               <= '0;
            bk_q                  <= '0;
            pending_q             <= '0;
            irq_ack               <= '0;
            irq_drop              <= '0;
            cfg_interrupt_msi_int <= '0;
            busy                  <= 1'b0;
        end else begin
            state_q               <= state_n;
            cur_src_q             <= cur_src_n;
            rr_ptr_q              <= rr_ptr_n;
            retry_q               <= retry_n;
            timer_q               <= timer_n;
            bk_q                  <= bk_n;
            pending_q             <= pending_n;
            irq_ack               <= ack_n;
            irq_drop              <= drop_n;
            cfg_interrupt_msi_int <= int_n;
            busy                  <= busy_n;
        end
    end

`ifdef MSI_IRQ_STATS_EN
    logic        sent_evt, fail_evt;
    logic [32:0] drop_sum;

    assign sent_evt = (state_q == S_WAIT) && cfg_interrupt_msi_sent;
    assign fail_evt = (state_q == S_WAIT) && !cfg_interrupt_msi_sent &&
                      (cfg_interrupt_msi_fail || (timer_q == TMR_LAST));
    assign drop_sum = {1'b0, stat_drop} + 33'($countones(drop_n));

    // Saturating event counters, updated on the same edge as the ack/drop pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent <= '0;
            stat_fail <= '0;
            stat_drop <= '0;
        end else begin
            if (sent_evt && (stat_sent != '1)) begin
                stat_sent <= stat_sent + 32'd1;
            end
            if (fail_evt && (stat_fail != '1)) begin
                stat_fail <= stat_fail + 32'd1;
            end
            stat_drop <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Self-checking bench for msi_irq_scheduler: vector-map table, directed corner sequences, randomized bursts vs. a round-robin model.
module tb_msi_irq_scheduler;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned RETRY_MAX = 3;
    localparam int unsigned BACKOFF = 16;
    localparam int unsigned TIMEOUT = 1024;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_req;
    logic [NUM_SRC-1:0] irq_ack;
    logic [NUM_SRC-1:0] irq_drop;
    logic [3:0]         msi_enable;
    logic [11:0]        msi_mmenable;
    logic [31:0]        msi_int;
    logic               msi_sent;
    logic               msi_fail;
    logic [7:0]         msi_fn;
    logic [2:0]         msi_attr;
    logic               busy;
`ifdef MSI_IRQ_STATS_EN
    logic [31:0]        stat_sent, stat_fail, stat_drop;
`endif

    msi_irq_scheduler #(
        .NUM_SRC(NUM_SRC), .RETRY_MAX(RETRY_MAX),
        .BACKOFF_CYCLES(BACKOFF), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .irq_req                           (irq_req),
        .irq_ack                           (irq_ack),
        .irq_drop                          (irq_drop),
        .cfg_interrupt_msi_enable          (msi_enable),
        .cfg_interrupt_msi_mmenable        (msi_mmenable),
        .cfg_interrupt_msi_int             (msi_int),
        .cfg_interrupt_msi_sent            (msi_sent),
        .cfg_interrupt_msi_fail            (msi_fail),
        .cfg_interrupt_msi_function_number (msi_fn),
        .cfg_interrupt_msi_attr            (msi_attr),
        .busy                              (busy)
`ifdef MSI_IRQ_STATS_EN
        ,
        .stat_sent                         (stat_sent),
        .stat_fail                         (stat_fail),
        .stat_drop                         (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mm;
        int          src;
        logic [31:0] exp_int;
    } vec_t;

    vec_t vtab[10];
    int   checks = 0;
    int   errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        irq_req  = '0;
        msi_sent = 1'b0;
        msi_fail = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) until an MSI pulse is visible at the sampling point.
    task automatic wait_int(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 3000) begin
            if (msi_int != 32'd0) begin
                ok = 1'b1;
                return;
            end
            tick();
            cycles++;
        end
        checks++;
        errors++;
        $display("FAIL wait_int: no interrupt within %0d cycles", cycles);
    endtask

    // Called in the ISSUE cycle; answers after 'delay' extra WAIT cycles, returns one cycle after the response.
    task automatic respond(input bit do_fail, input int delay);
        tick();
        check("int_one_cycle", msi_int, 32'd0);
        repeat (delay) tick();
        if (do_fail) msi_fail = 1'b1;
        else         msi_sent = 1'b1;
        tick();
        msi_sent = 1'b0;
        msi_fail = 1'b0;
    endtask

    function automatic logic [31:0] model_vec(input int src, input logic [2:0] mm);
        int lg;
        lg = (mm > 3'd5) ? 5 : int'(mm);
        return 32'd1 << (src % (1 << lg));
    endfunction

    initial begin
        int          cyc;
        bit          ok;
        bit          seen;
        logic [31:0] first_vec;
        bit          pend_m[NUM_SRC];
        int          rr_m;
        int          src;
        int          attempts;
        bit          done;
        bit          f;
        logic [2:0]  mm;
        logic [7:0]  mask;
        bit          bail;

        vtab[0] = '{3'd3, 2, 32'h4};
        vtab[1] = '{3'd1, 5, 32'h2};
        vtab[2] = '{3'd0, 7, 32'h1};
        vtab[3] = '{3'd2, 6, 32'h4};
        vtab[4] = '{3'd5, 7, 32'h80};
        vtab[5] = '{3'd7, 3, 32'h8};
        vtab[6] = '{3'd6, 5, 32'h20};
        vtab[7] = '{3'd4, 6, 32'h40};
        vtab[8] = '{3'd2, 3, 32'h8};
        vtab[9] = '{3'd1, 4, 32'h1};

        rst_n        = 1'b0;
        irq_req      = '0;
        msi_sent     = 1'b0;
        msi_fail     = 1'b0;
        msi_enable   = 4'h1;
        msi_mmenable = 12'd3;
        tick();
        check("reset_int", msi_int, 32'd0);
        check("reset_ack", 32'(irq_ack), 32'd0);
        check("reset_drop", 32'(irq_drop), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("func_num", 32'(msi_fn), 32'd0);
        check("attr", 32'(msi_attr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request: 2-cycle latency, one-cycle int, ack, busy drops.
        irq_req = 8'h04;
        tick();
        irq_req = '0;
        check("lat_int_cycle1", msi_int, 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("lat_int_cycle2", msi_int, 32'h4);
        respond(1'b0, 4);
        check("lat_ack", 32'(irq_ack), 32'h4);
        check("lat_busy_idle", 32'(busy), 32'd0);
        tick();
        check("lat_ack_once", 32'(irq_ack), 32'd0);

        // Vector-map table.
        foreach (vtab[i]) begin
            msi_mmenable = {9'd0, vtab[i].mm};
            irq_req = 8'(32'd1 << vtab[i].src);
            tick();
            irq_req = '0;
            wait_int(cyc, ok);
            check($sformatf("vtab%0d_int", i), msi_int, vtab[i].exp_int);
            respond(1'b0, 1);
            check($sformatf("vtab%0d_ack", i), 32'(irq_ack), 32'd1 << vtab[i].src);
        end
        msi_mmenable = 12'd3;

        // Round-robin order and wrap.
        do_reset();
        irq_req = 8'h81;
        tick();
        irq_req = '0;
        wait_int(cyc, ok);
        check("rr_first", msi_int, 32'h1);
        respond(1'b0, 0);
        check("rr_ack0", 32'(irq_ack), 32'h1);
        wait_int(cyc, ok);
        check("rr_second", msi_int, 32'h80);
        respond(1'b0, 0);
        check("rr_ack7", 32'(irq_ack), 32'h80);
        irq_req = 8'h81;
        tick();
        irq_req = '0;
        wait_int(cyc, ok);
        check("rr_wrap", msi_int, 32'h1);
        respond(1'b0, 0);
        wait_int(cyc, ok);
        respond(1'b0, 0);

        // Request coinciding with its own ack re-arms the source.
        irq_req = 8'h04;
        tick();
        irq_req = '0;
        wait_int(cyc, ok);
        tick();
        msi_sent = 1'b1;
        irq_req  = 8'h04;
        tick();
        msi_sent = 1'b0;
        irq_req  = '0;
        check("setwin_ack", 32'(irq_ack), 32'h4);
        check("setwin_busy", 32'(busy), 32'd1);
        wait_int(cyc, ok);
        check("setwin_reissue", msi_int, 32'h4);
        respond(1'b0, 0);
        check("setwin_ack2", 32'(irq_ack), 32'h4);

        // Fail every attempt: spacing, then drop without ack.
        do_reset();
        irq_req = 8'h08;
        tick();
        irq_req = '0;
        wait_int(cyc, ok);
        for (int a = 1; a <= int'(RETRY_MAX); a++) begin
            check($sformatf("retry%0d_int", a), msi_int, 32'h8);
            respond(1'b1, 0);
            check($sformatf("retry%0d_ack", a), 32'(irq_ack), 32'd0);
            if (a < int'(RETRY_MAX)) begin
                check($sformatf("retry%0d_nodrop", a), 32'(irq_drop), 32'd0);
                wait_int(cyc, ok);
                check($sformatf("retry%0d_spacing", a), 32'(cyc + 2), 32'(BACKOFF + 2));
            end else begin
                check("retry_drop", 32'(irq_drop), 32'h8);
`ifdef MSI_IRQ_STATS_EN
                check("stat_fail", stat_fail, 32'd3);
                check("stat_drop", stat_drop, 32'd1);
                check("stat_sent", stat_sent, 32'd0);
`endif
            end
        end
        tick();
        check("retry_drop_once", 32'(irq_drop), 32'd0);
        check("retry_busy", 32'(busy), 32'd0);

        // Lost response: timeout then reissue; async reset mid-WAIT.
        irq_req = 8'h02;
        tick();
        irq_req = '0;
        wait_int(cyc, ok);
        tick();
        check("to_int_low", msi_int, 32'd0);
        wait_int(cyc, ok);
        check("to_spacing", 32'(cyc + 1), 32'(TIMEOUT + BACKOFF + 1));
        check("to_reissue", msi_int, 32'h2);
        repeat (6) tick();
        #1 rst_n = 1'b0;
        #1;
        check("rst_int", msi_int, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_drop", 32'(irq_drop), 32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (msi_int != 32'd0 || busy) seen = 1'b1;
        end
        check("rst_quiet", 32'(seen), 32'd0);

        // MSI disabled: bulk drop, no interrupt.
        msi_enable = 4'h0;
        irq_req = 8'h0F;
        tick();
        irq_req = '0;
        check("dis_int0", msi_int, 32'd0);
        tick();
        check("dis_drop", 32'(irq_drop), 32'h0F);
        check("dis_int1", msi_int, 32'd0);
        tick();
        check("dis_drop_once", 32'(irq_drop), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        msi_enable = 4'h1;

        // Randomized bursts against a round-robin model.
        do_reset();
        rr_m = 0;
        bail = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) pend_m[i] = 1'b0;
        for (int b = 0; b < 25 && !bail; b++) begin
            mm = 3'($urandom_range(0, 7));
            mask = 8'($urandom_range(1, 255));
            msi_mmenable = {9'd0, mm};
            irq_req = mask;
            tick();
            irq_req = '0;
            for (int i = 0; i < int'(NUM_SRC); i++) if (mask[i]) pend_m[i] = 1'b1;
            forever begin
                src = -1;
                for (int k = 0; k < int'(NUM_SRC); k++) begin
                    if (src < 0 && pend_m[(rr_m + k) % int'(NUM_SRC)]) src = (rr_m + k) % int'(NUM_SRC);
                end
                if (src < 0) break;
                attempts = 0;
                done = 1'b0;
                while (!done) begin
                    wait_int(cyc, ok);
                    if (!ok) begin
                        bail = 1'b1;
                        break;
                    end
                    check($sformatf("rnd%0d_src%0d_int", b, src), msi_int, model_vec(src, mm));
                    f = ($urandom_range(0, 2) == 0);
                    respond(f, int'($urandom_range(0, 4)));
                    if (!f || attempts + 1 == int'(RETRY_MAX)) begin
                        check($sformatf("rnd%0d_src%0d_ack", b, src), 32'(irq_ack), f ? 32'd0 : 32'd1 << src);
                        check($sformatf("rnd%0d_src%0d_drop", b, src), 32'(irq_drop), f ? 32'd1 << src : 32'd0);
                        pend_m[src] = 1'b0;
                        rr_m = (src + 1) % int'(NUM_SRC);
                        done = 1'b1;
                    end else begin
                        attempts++;
                        check($sformatf("rnd%0d_src%0d_quiet", b, src), 32'({irq_ack, irq_drop}), 32'd0);
                    end
                end
                if (bail) break;
            end
            check($sformatf("rnd%0d_busy", b), 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
